// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regbank_write_arbiter: shares the register_bank write port between ALU
// writeback and an in-order load FIFO, with starvation and WAW guards. Rev 1.0
// ----------------------------------------------------------------------------
module regbank_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ALU_Valid,
  input  logic [3:0]  ALU_Dest,
  input  logic [31:0] ALU_Data,
  output logic        ALU_Stall,
  input  logic        LDR_Valid,
  input  logic [3:0]  LDR_Dest,
  input  logic [31:0] LDR_Data,
  output logic        LDR_Ready,
  input  logic [3:0]  Source1_ADDR,
  input  logic [3:0]  Source2_ADDR,
  output logic        Source1_Hazard,
  output logic        Source2_Hazard,
  output logic        Bank_Write_Enable,
  output logic [3:0]  Bank_Destination,
  output logic [31:0] Bank_Write_Data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [3:0]            ent_dest_q [FIFO_DEPTH];
  logic [3:0]            ent_dest_d [FIFO_DEPTH];
  logic [31:0]           ent_data_q [FIFO_DEPTH];
  logic [31:0]           ent_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic                  bank_we_q, bank_we_d;
  logic [3:0]            bank_dest_q, bank_dest_d;
  logic [31:0]           bank_data_q, bank_data_d;

  logic head_v;
  logic full;
  logic starve;
  logic waw;
  logic alu_grant;
  logic ld_grant;
  logic push;
  logic haz1;
  logic haz2;

  // Grant decision and source-address matching, all from current state.
  always_comb begin
    head_v = (occ_q != '0);
    full   = (occ_q == OCC_W'(FIFO_DEPTH));
    starve = head_v && (starve_q == SC_W'(STARVE_LIMIT));
    waw    = 1'b0;
    haz1   = bank_we_q && (bank_dest_q == Source1_ADDR);
    haz2   = bank_we_q && (bank_dest_q == Source2_ADDR);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid_q[i]) begin
        if (ent_dest_q[i] == ALU_Dest)     waw  = 1'b1;
        if (ent_dest_q[i] == Source1_ADDR) haz1 = 1'b1;
        if (ent_dest_q[i] == Source2_ADDR) haz2 = 1'b1;
      end
    end
    waw       = waw && ALU_Valid;
    alu_grant = ALU_Valid && !(starve || waw);
    ld_grant  = head_v && !alu_grant;
    push      = LDR_Valid && !full;
  end

  always_comb begin
    ent_dest_d  = ent_dest_q;
    ent_data_d  = ent_data_q;
    ent_valid_d = ent_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    starve_d    = starve_q;
    bank_we_d   = 1'b0;
    bank_dest_d = bank_dest_q;
    bank_data_d = bank_data_q;

    if (push) begin
      ent_dest_d[wr_ptr_q]  = LDR_Dest;
      ent_data_d[wr_ptr_q]  = LDR_Data;
      ent_valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    // Pop slot never equals push slot: a pop needs an entry and a push needs room.
    if (ld_grant) begin
      ent_valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = rd_ptr_q + PTR_W'(1);
    end

    case ({push, ld_grant})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (ld_grant || !head_v) begin
      starve_d = '0;
    end else if (alu_grant && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end

    if (alu_grant) begin
      bank_we_d   = 1'b1;
      bank_dest_d = ALU_Dest;
      bank_data_d = ALU_Data;
    end else if (ld_grant) begin
      bank_we_d   = 1'b1;
      bank_dest_d = ent_dest_q[rd_ptr_q];
      bank_data_d = ent_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ent_valid_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      starve_q    <= '0;
      bank_we_q   <= 1'b0;
      bank_dest_q <= '0;
      bank_data_q <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      starve_q    <= starve_d;
      bank_we_q   <= bank_we_d;
      bank_dest_q <= bank_dest_d;
      bank_data_q <= bank_data_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every use.
  always_ff @(posedge Clock) begin
    ent_dest_q <= ent_dest_d;
    ent_data_q <= ent_data_d;
  end

  assign ALU_Stall         = ALU_Valid && (starve || waw);
  assign LDR_Ready         = !full;
  assign Source1_Hazard    = haz1;
  assign Source2_Hazard    = haz2;
  assign Bank_Write_Enable = bank_we_q;
  assign Bank_Destination  = bank_dest_q;
  assign Bank_Write_Data   = bank_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regbank_write_arbiter: scenario tasks plus a write-port scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
module tb_regbank_write_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ALU_Valid = 1'b0;
  logic [3:0]  ALU_Dest = '0;
  logic [31:0] ALU_Data = '0;
  logic        ALU_Stall;
  logic        LDR_Valid = 1'b0;
  logic [3:0]  LDR_Dest = '0;
  logic [31:0] LDR_Data = '0;
  logic        LDR_Ready;
  logic [3:0]  Source1_ADDR = '0;
  logic [3:0]  Source2_ADDR = '0;
  logic        Source1_Hazard;
  logic        Source2_Hazard;
  logic        Bank_Write_Enable;
  logic [3:0]  Bank_Destination;
  logic [31:0] Bank_Write_Data;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q [$];
  logic [35:0] exp_w;
  logic [31:0] bank_model [16];

  regbank_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .ALU_Valid         (ALU_Valid),
    .ALU_Dest          (ALU_Dest),
    .ALU_Data          (ALU_Data),
    .ALU_Stall         (ALU_Stall),
    .LDR_Valid         (LDR_Valid),
    .LDR_Dest          (LDR_Dest),
    .LDR_Data          (LDR_Data),
    .LDR_Ready         (LDR_Ready),
    .Source1_ADDR      (Source1_ADDR),
    .Source2_ADDR      (Source2_ADDR),
    .Source1_Hazard    (Source1_Hazard),
    .Source2_Hazard    (Source2_Hazard),
    .Bank_Write_Enable (Bank_Write_Enable),
    .Bank_Destination  (Bank_Destination),
    .Bank_Write_Data   (Bank_Write_Data)
  );

  always #5 Clock = ~Clock;

  // Every bank write must be the next expected {dest, data}, in order.
  always @(negedge Clock) begin
    if (Bank_Write_Enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got dest=%0d data=%h, required no write",
                 Bank_Destination, Bank_Write_Data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({Bank_Destination, Bank_Write_Data} !== exp_w) begin
          errors++;
          $display("FAIL write_order: got dest=%0d data=%h, required dest=%0d data=%h",
                   Bank_Destination, Bank_Write_Data, exp_w[35:32], exp_w[31:0]);
        end
      end
      bank_model[Bank_Destination] = Bank_Write_Data;
    end
  end

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({Bank_Write_Enable, Bank_Destination, Bank_Write_Data} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b dest=%0d data=%h, required all 0",
               Bank_Write_Enable, Bank_Destination, Bank_Write_Data);
    end
    checks++;
    if ({LDR_Ready, ALU_Stall, Source1_Hazard, Source2_Hazard} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got ready/stall/h1/h2=%b, required 1000",
               {LDR_Ready, ALU_Stall, Source1_Hazard, Source2_Hazard});
    end
    Reset = 1'b0;
  endtask

  task automatic test_alu_write;
    ALU_Valid = 1'b1; ALU_Dest = 4'd3; ALU_Data = 32'h0000_00AA;
    #1;
    checks++;
    if (ALU_Stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall_idle: got %b, required 0", ALU_Stall);
    end
    exp_q.push_back({4'd3, 32'h0000_00AA});
    step();
    ALU_Valid = 1'b0;
    checks++;
    if ({Bank_Write_Enable, Bank_Destination, Bank_Write_Data} !== {1'b1, 4'd3, 32'hAA}) begin
      errors++;
      $display("FAIL alu_latency: got we=%b dest=%0d data=%h, required we=1 dest=3 data=aa",
               Bank_Write_Enable, Bank_Destination, Bank_Write_Data);
    end
    step();
    checks++;
    if (Bank_Write_Enable !== 1'b0) begin
      errors++; $display("FAIL alu_we_drop: got %b, required 0", Bank_Write_Enable);
    end
  endtask

  task automatic test_load_latency;
    Source1_ADDR = 4'd5;
    LDR_Valid = 1'b1; LDR_Dest = 4'd5; LDR_Data = 32'h1234_5678;
    #1;
    checks++;
    if ({LDR_Ready, Source1_Hazard} !== 2'b10) begin
      errors++; $display("FAIL load_pre: got ready/h1=%b, required 10", {LDR_Ready, Source1_Hazard});
    end
    exp_q.push_back({4'd5, 32'h1234_5678});
    step();
    LDR_Valid = 1'b0;
    #1;
    checks++;
    if ({Source1_Hazard, Bank_Write_Enable} !== 2'b10) begin
      errors++; $display("FAIL load_n1: got h1/we=%b, required 10", {Source1_Hazard, Bank_Write_Enable});
    end
    step();
    checks++;
    if ({Source1_Hazard, Bank_Write_Enable, Bank_Destination} !== {2'b11, 4'd5}) begin
      errors++;
      $display("FAIL load_n2: got h1=%b we=%b dest=%0d, required h1=1 we=1 dest=5",
               Source1_Hazard, Bank_Write_Enable, Bank_Destination);
    end
    step();
    checks++;
    if ({Source1_Hazard, Bank_Write_Enable} !== 2'b00) begin
      errors++; $display("FAIL load_n3: got h1/we=%b, required 00", {Source1_Hazard, Bank_Write_Enable});
    end
    Source1_ADDR = 4'd0;
  endtask

  task automatic test_starvation;
    LDR_Valid = 1'b1; LDR_Dest = 4'd7; LDR_Data = 32'h77;
    step();
    LDR_Valid = 1'b0;
    ALU_Valid = 1'b1; ALU_Dest = 4'd1; ALU_Data = 32'hA1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ALU_Stall !== 1'b0) begin
        errors++; $display("FAIL starve_alu_win%0d: got stall=%b, required 0", k, ALU_Stall);
      end
      exp_q.push_back({4'd1, 32'hA1});
      step();
    end
    #1;
    checks++;
    if (ALU_Stall !== 1'b1) begin
      errors++; $display("FAIL starve_stall: got %b, required 1", ALU_Stall);
    end
    exp_q.push_back({4'd7, 32'h77});
    step();
    #1;
    checks++;
    if (ALU_Stall !== 1'b0) begin
      errors++; $display("FAIL starve_resume: got %b, required 0", ALU_Stall);
    end
    exp_q.push_back({4'd1, 32'hA1});
    step();
    ALU_Valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_waw;
    LDR_Valid = 1'b1; LDR_Dest = 4'd9; LDR_Data = 32'h11;
    step();
    LDR_Valid = 1'b0;
    ALU_Valid = 1'b1; ALU_Dest = 4'd9; ALU_Data = 32'h22;
    #1;
    checks++;
    if (ALU_Stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall: got %b, required 1", ALU_Stall);
    end
    exp_q.push_back({4'd9, 32'h11});
    step();
    checks++;
    if (ALU_Stall !== 1'b0) begin
      errors++; $display("FAIL waw_release: got %b, required 0", ALU_Stall);
    end
    exp_q.push_back({4'd9, 32'h22});
    step();
    ALU_Valid = 1'b0;
    step();
    step();
    checks++;
    if (bank_model[9] !== 32'h22) begin
      errors++; $display("FAIL waw_final_r9: got %h, required 00000022", bank_model[9]);
    end
  endtask

  task automatic test_full;
    Source2_ADDR = 4'd13;
    ALU_Valid = 1'b1; ALU_Dest = 4'd2;
    for (int k = 0; k < 4; k++) begin
      ALU_Data  = 32'hB0 + 32'(k);
      LDR_Valid = 1'b1; LDR_Dest = 4'(10 + k); LDR_Data = 32'h100 + 32'(k);
      #1;
      checks++;
      if ({LDR_Ready, ALU_Stall} !== 2'b10) begin
        errors++; $display("FAIL fill_%0d: got ready/stall=%b, required 10", k, {LDR_Ready, ALU_Stall});
      end
      exp_q.push_back({4'd2, 32'hB0 + 32'(k)});
      step();
    end
    ALU_Data = 32'hB4; LDR_Dest = 4'd14; LDR_Data = 32'h104;
    #1;
    checks++;
    if ({LDR_Ready, ALU_Stall, Source2_Hazard} !== 3'b011) begin
      errors++;
      $display("FAIL full_state: got ready/stall/h2=%b, required 011",
               {LDR_Ready, ALU_Stall, Source2_Hazard});
    end
    exp_q.push_back({4'd10, 32'h100});
    step();
    #1;
    checks++;
    if ({LDR_Ready, ALU_Stall} !== 2'b10) begin
      errors++; $display("FAIL after_pop: got ready/stall=%b, required 10", {LDR_Ready, ALU_Stall});
    end
    exp_q.push_back({4'd2, 32'hB4});
    step();
    ALU_Valid = 1'b0; LDR_Valid = 1'b0;
    for (int k = 1; k < 5; k++) exp_q.push_back({4'(10 + k), 32'h100 + 32'(k)});
    for (int k = 0; k < 6; k++) step();
    checks++;
    if ({LDR_Ready, Source2_Hazard} !== 2'b10) begin
      errors++; $display("FAIL full_drained: got ready/h2=%b, required 10", {LDR_Ready, Source2_Hazard});
    end
    Source2_ADDR = 4'd0;
  endtask

  task automatic test_reset_mid;
    Source1_ADDR = 4'd4; Source2_ADDR = 4'd6;
    ALU_Valid = 1'b1; ALU_Dest = 4'd0; ALU_Data = 32'hC0;
    LDR_Valid = 1'b1; LDR_Dest = 4'd4; LDR_Data = 32'h44;
    exp_q.push_back({4'd0, 32'hC0});
    step();
    ALU_Data = 32'hC1; LDR_Dest = 4'd6; LDR_Data = 32'h66;
    exp_q.push_back({4'd0, 32'hC1});
    step();
    ALU_Dest = 4'd8; ALU_Data = 32'hC2; LDR_Dest = 4'd15; LDR_Data = 32'hFF;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Source1_Hazard, Source2_Hazard} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_hazards: got %b, required 11", {Source1_Hazard, Source2_Hazard});
    end
    step();
    #1;
    checks++;
    if ({Bank_Write_Enable, Bank_Destination, Bank_Write_Data} !== 37'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%b dest=%0d data=%h, required all 0",
               Bank_Write_Enable, Bank_Destination, Bank_Write_Data);
    end
    checks++;
    if ({LDR_Ready, Source1_Hazard, Source2_Hazard} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_flags: got ready/h1/h2=%b, required 100",
               {LDR_Ready, Source1_Hazard, Source2_Hazard});
    end
    Reset = 1'b0; ALU_Valid = 1'b0; LDR_Valid = 1'b0;
    step();
    step();
    checks++;
    if ({Bank_Write_Enable, LDR_Ready, Source1_Hazard, Source2_Hazard} !== 4'b0100) begin
      errors++;
      $display("FAIL post_reset_idle: got we/ready/h1/h2=%b, required 0100",
               {Bank_Write_Enable, LDR_Ready, Source1_Hazard, Source2_Hazard});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank_model[i] = '0;
    test_reset();
    test_alu_write();
    test_load_latency();
    test_starvation();
    test_waw();
    test_full();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
